// File: rtl/acq_window_sched_pkg.sv
// Shared types and default widths for the acquisition window scheduler.
package acq_window_pkg;

    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned WCNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // First state of a window sequence given which config fields are non-zero.
    function automatic state_e launch_state(input logic period_nz, input logic len_nz);
        if (period_nz) begin
            return WAIT;
        end
        if (len_nz) begin
            return CAPTURE;
        end
        return DONE;
    endfunction

endpackage

// File: rtl/acq_window_sched_counter.sv
// Enable-gated counter with synchronous clear; clear only acts while enabled.
module counter_wrap_sync #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [DW-1:0] cnt_o
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = clr_i ? '0 : cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/acq_window_sched.sv
// Acquisition window scheduler: delay, open a window of len valid samples, close,
// optionally repeat. First/last/done/aborted are decoded in the current cycle.
module acq_window_sched
    import acq_window_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned WCNT_W = WCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              cont_i,
    input  logic [DW-1:0]     period_i,
    input  logic [DW-1:0]     len_i,
    input  logic              sample_valid_i,
    output logic              busy_o,
    output logic              win_open_o,
    output logic              win_first_o,
    output logic              win_last_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [WCNT_W-1:0] win_count_o
);

    state_e        state_q, state_d;
    logic [DW-1:0] period_q, period_d;
    logic [DW-1:0] len_q, len_d;
    logic          cont_q, cont_d;

    logic [DW-1:0] cnt;
    logic          cnt_en, cnt_clr;
    logic          wc_en, wc_clr;
    logic          first_c, last_c, done_c;
    logic          busy_c, abort_c;
    logic          wait_end_c, cap_end_c;

    assign busy_c     = (state_q != IDLE);
    assign abort_c    = abort_i & busy_c;
    assign wait_end_c = (cnt == period_q - DW'(1));
    assign cap_end_c  = (cnt == len_q - DW'(1));

    // Next-state, counter control and per-cycle event decode.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        len_d    = len_q;
        cont_d   = cont_q;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        wc_en    = 1'b0;
        wc_clr   = 1'b0;
        first_c  = 1'b0;
        last_c   = 1'b0;
        done_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    period_d = period_i;
                    len_d    = len_i;
                    cont_d   = cont_i;
                    wc_en    = 1'b1;
                    wc_clr   = 1'b1;
                    cnt_en   = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = launch_state(|period_i, |len_i);
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (abort_c) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (wait_end_c) begin
                    cnt_clr = 1'b1;
                    // A zero-length window skips straight to completion.
                    state_d = (|len_q) ? CAPTURE : DONE;
                end
            end
            CAPTURE: begin
                if (abort_c) begin
                    cnt_en  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (sample_valid_i) begin
                    cnt_en  = 1'b1;
                    first_c = (cnt == '0);
                    if (cap_end_c) begin
                        last_c  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort_c) begin
                    cnt_en  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    done_c  = 1'b1;
                    wc_en   = 1'b1;
                    state_d = cont_q ? launch_state(|period_q, |len_q) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            len_q    <= '0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            len_q    <= len_d;
            cont_q   <= cont_d;
        end
    end

    counter_wrap_sync #(.DW(DW)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (cnt_en),
        .clr_i (cnt_clr),
        .cnt_o (cnt)
    );

    counter_wrap_sync #(.DW(WCNT_W)) u_win_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (wc_en),
        .clr_i (wc_clr),
        .cnt_o (win_count_o)
    );

    assign busy_o      = busy_c;
    assign win_open_o  = (state_q == CAPTURE);
    assign win_first_o = first_c;
    assign win_last_o  = last_c;
    assign done_o      = done_c;
    assign aborted_o   = abort_c;

endmodule

// File: tb/tb_acq_window_sched.sv
// Bench for acq_window_sched: directed scenarios plus random traffic against a
// phase/remaining-count model of the scheduler.
module tb_acq_window_sched;

    localparam int unsigned DW = 16;
    localparam int unsigned WW = 2;

    logic          clk = 1'b0;
    logic          rst, start_i, abort_i, cont_i, sample_valid_i;
    logic [DW-1:0] period_i, len_i;
    logic          busy_o, win_open_o, win_first_o, win_last_o, done_o, aborted_o;
    logic [WW-1:0] win_count_o;

    always #5 clk = ~clk;

    acq_window_sched #(.DW(DW), .WCNT_W(WW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .cont_i         (cont_i),
        .period_i       (period_i),
        .len_i          (len_i),
        .sample_valid_i (sample_valid_i),
        .busy_o         (busy_o),
        .win_open_o     (win_open_o),
        .win_first_o    (win_first_o),
        .win_last_o     (win_last_o),
        .done_o         (done_o),
        .aborted_o      (aborted_o),
        .win_count_o    (win_count_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 delaying, 2 window open, 3 completion cycle.
    int ph = 0, wait_left = 0, got = 0, m_period = 0, m_len = 0, m_wins = 0;
    bit m_cont = 1'b0;
    bit chk_en = 1'b0;

    task automatic m_launch();
        if (m_period != 0) begin
            ph = 1; wait_left = m_period;
        end else if (m_len != 0) begin
            ph = 2; got = 0;
        end else begin
            ph = 3;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; wait_left = 0; got = 0; m_period = 0; m_len = 0; m_cont = 0; m_wins = 0;
        end else begin
            case (ph)
                0: if (start_i) begin
                    m_period = int'(period_i);
                    m_len    = int'(len_i);
                    m_cont   = cont_i;
                    m_wins   = 0;
                    m_launch();
                end
                1: if (abort_i) ph = 0;
                   else begin
                       wait_left--;
                       if (wait_left == 0) begin
                           if (m_len != 0) begin ph = 2; got = 0; end
                           else ph = 3;
                       end
                   end
                2: if (abort_i) ph = 0;
                   else if (sample_valid_i) begin
                       if (got == m_len - 1) ph = 3;
                       else got++;
                   end
                default: if (abort_i) ph = 0;
                   else begin
                       m_wins = (m_wins + 1) % int'(1 << WW);
                       if (m_cont) m_launch();
                       else ph = 0;
                   end
            endcase
        end
    end

    // Observation counters for the directed scenarios.
    int  o_open, o_first, o_last, o_fl, o_done, o_abort, o_busy, first_idx, last_idx;
    bit  pend_wc;
    int  wc_q[$];

    task automatic clr_obs();
        o_open = 0; o_first = 0; o_last = 0; o_fl = 0; o_done = 0; o_abort = 0; o_busy = 0;
        first_idx = 0; last_idx = 0; pend_wc = 0; wc_q.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_ab, e_open, e_first, e_last, e_done;
            e_ab    = abort_i && (ph != 0);
            e_open  = (ph == 2);
            e_first = e_open && sample_valid_i && (got == 0) && !e_ab;
            e_last  = e_open && sample_valid_i && (got == m_len - 1) && !e_ab;
            e_done  = (ph == 3) && !e_ab;
            chk("busy",    32'(busy_o),      32'(ph != 0));
            chk("open",    32'(win_open_o),  32'(e_open));
            chk("first",   32'(win_first_o), 32'(e_first));
            chk("last",    32'(win_last_o),  32'(e_last));
            chk("done",    32'(done_o),      32'(e_done));
            chk("aborted", 32'(aborted_o),   32'(e_ab));
            chk("wcount",  32'(win_count_o), 32'(m_wins));

            if (pend_wc) begin
                wc_q.push_back(int'(win_count_o));
                pend_wc = 1'b0;
            end
            if (win_open_o) o_open++;
            if (win_first_o) begin o_first++; first_idx = o_open; end
            if (win_last_o) begin o_last++; last_idx = o_open; end
            if (win_first_o && win_last_o) o_fl++;
            if (done_o) begin o_done++; pend_wc = 1'b1; end
            if (aborted_o) o_abort++;
            if (busy_o) o_busy++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input int p, input int l, input bit c);
        start_i = 1'b1; period_i = DW'(p); len_i = DW'(l); cont_i = c;
        cyc(1);
        start_i = 1'b0;
        period_i = DW'($urandom_range(0, 9)); len_i = DW'($urandom_range(0, 9)); cont_i = ~c;
    endtask

    initial begin
        int exp_wc[5];
        exp_wc = '{1, 2, 3, 0, 1};
        rst = 1'b1; start_i = 0; abort_i = 0; cont_i = 0; sample_valid_i = 0;
        period_i = '0; len_i = '0;
        clr_obs();
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_open", 32'(win_open_o), 0);
        chk("rst_wcount", 32'(win_count_o), 0);

        // One-shot: 3 delay cycles, 4-sample window.
        clr_obs(); sample_valid_i = 1'b1;
        go(3, 4, 1'b0);
        cyc(15);
        chk("os_open", 32'(o_open), 4);
        chk("os_first_idx", 32'(first_idx), 1);
        chk("os_last_idx", 32'(last_idx), 4);
        chk("os_done", 32'(o_done), 1);
        chk("os_busy_cycles", 32'(o_busy), 8);
        chk("os_wcount", 32'(win_count_o), 1);

        // Sparse valid: every third cycle.
        clr_obs(); sample_valid_i = 1'b0;
        go(0, 3, 1'b0);
        for (int i = 0; i < 12; i++) begin
            sample_valid_i = (i % 3 == 2);
            cyc(1);
        end
        sample_valid_i = 1'b0;
        cyc(3);
        chk("sp_open", 32'(o_open), 9);
        chk("sp_first", 32'(o_first), 1);
        chk("sp_last", 32'(o_last), 1);
        chk("sp_first_idx", 32'(first_idx), 3);
        chk("sp_last_idx", 32'(last_idx), 9);

        // Continuous with wrap, abort in the sixth delay phase.
        clr_obs(); sample_valid_i = 1'b1;
        go(2, 2, 1'b1);
        cyc(25);
        abort_i = 1'b1;
        cyc(1);
        abort_i = 1'b0;
        cyc(3);
        chk("ct_done", 32'(o_done), 5);
        chk("ct_abort", 32'(o_abort), 1);
        chk("ct_open", 32'(o_open), 10);
        chk("ct_busy", 32'(busy_o), 0);
        chk("ct_wcount", 32'(win_count_o), 1);
        chk("ct_wc_len", 32'(wc_q.size()), 5);
        for (int i = 0; i < 5 && i < wc_q.size(); i++) chk("ct_wc_seq", 32'(wc_q[i]), 32'(exp_wc[i]));

        // len=0: only a done pulse.
        clr_obs();
        go(0, 0, 1'b0);
        cyc(4);
        chk("l0_open", 32'(o_open), 0);
        chk("l0_done", 32'(o_done), 1);
        chk("l0_wcount", 32'(win_count_o), 1);

        // len=1: first and last together.
        clr_obs(); sample_valid_i = 1'b1;
        go(1, 1, 1'b0);
        cyc(5);
        chk("l1_first_last", 32'(o_fl), 1);
        chk("l1_done", 32'(o_done), 1);

        // Abort in the completion cycle with cont set; start while open is ignored.
        clr_obs(); sample_valid_i = 1'b1;
        go(1, 1, 1'b1);
        cyc(1);
        start_i = 1'b1; period_i = '0; len_i = DW'(5);
        cyc(1);
        start_i = 1'b0; abort_i = 1'b1;
        cyc(1);
        abort_i = 1'b0;
        cyc(3);
        chk("ad_done", 32'(o_done), 0);
        chk("ad_abort", 32'(o_abort), 1);
        chk("ad_open", 32'(o_open), 1);
        chk("ad_busy", 32'(busy_o), 0);
        chk("ad_wcount", 32'(win_count_o), 0);

        // Reset mid-window.
        clr_obs(); sample_valid_i = 1'b1;
        go(0, 10, 1'b0);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rs_outputs", 32'({busy_o, win_open_o, win_first_o, win_last_o, done_o, aborted_o, win_count_o}), 0);
        chk("rs_pulses", 32'(o_done + o_abort), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 399) == 0);
            start_i        = ($urandom_range(0, 7) == 0);
            abort_i        = ($urandom_range(0, 39) == 0);
            cont_i         = 1'($urandom_range(0, 1));
            period_i       = DW'($urandom_range(0, 5));
            len_i          = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom_range(1, 6));
            sample_valid_i = ($urandom_range(0, 9) < 7);
            cyc(1);
        end
        rst = 1'b0; start_i = 1'b0; abort_i = 1'b1;
        cyc(1);
        abort_i = 1'b0;
        cyc(5);
        chk("end_idle", 32'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
